// File: rtl/sd_dev_cmd_layer_if.sv
// ---------------------------------------------------------------------------
// sd_dev_cmd_layer_if
// Card-logic side of the SD device command layer: decoded host commands out,
// response requests in.
//   o_cmd_stb        one-cycle pulse, o_cmd/o_cmd_arg hold a valid command
//   o_cmd, o_cmd_arg received index / argument (held until next valid command)
//   o_crc_err        one-cycle pulse, command CRC7 mismatch
//   o_frame_err      one-cycle pulse, command end bit was 0
//   i_rsp_en         pulse, load a response (honoured only while waiting)
//   i_rsp_skip       pulse, no response for this command
//   i_rsp_long_flag  sampled with i_rsp_en, 1 = 136-bit R2
//   i_rsp            short: [37:0] index+argument, long: [127:8] payload
//   o_busy           high whenever the engine is not idle
//   dbg_state        current FSM state (IDLE=0, RX=1, WAIT_RSP=2, TX=3)
// Handshake: i_rsp_en/i_rsp_skip are single-cycle requests, sampled on the
// rising edge; there is no ready -- a request that arrives outside the
// response window, or after a response is already loaded, is dropped.
// ---------------------------------------------------------------------------
interface sd_dev_cmd_layer_if;
   logic         o_cmd_stb;
   logic [5:0]   o_cmd;
   logic [31:0]  o_cmd_arg;
   logic         o_crc_err;
   logic         o_frame_err;
   logic         i_rsp_en;
   logic         i_rsp_skip;
   logic         i_rsp_long_flag;
   logic [127:0] i_rsp;
   logic         o_busy;
   logic [1:0]   dbg_state;

   // slave: the command layer; master: the card logic driving responses
   modport slave (
      output o_cmd_stb, o_cmd, o_cmd_arg, o_crc_err, o_frame_err, o_busy, dbg_state,
      input  i_rsp_en, i_rsp_skip, i_rsp_long_flag, i_rsp
   );
   modport master (
      input  o_cmd_stb, o_cmd, o_cmd_arg, o_crc_err, o_frame_err, o_busy, dbg_state,
      output i_rsp_en, i_rsp_skip, i_rsp_long_flag, i_rsp
   );
endinterface

// File: rtl/sd_dev_cmd_layer.sv
// ---------------------------------------------------------------------------
// sd_dev_cmd_layer
// Card-side SD CMD line engine. Deserialises 48-bit host command tokens,
// checks transmission bit, end bit and CRC7, hands index/argument to the card
// logic, then serialises a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response with
// a generated CRC7.
//   clk, rst      SD clock, synchronous active-high reset
//   i_sd_cmd      CMD line as seen by the card
//   o_sd_cmd      CMD value driven by the card (1 when released)
//   o_sd_cmd_dir  1 = card drives CMD
//   bus           card-logic interface (slave modport)
// ---------------------------------------------------------------------------
module sd_dev_cmd_layer #(
   parameter int NCR_MIN = 2,
   parameter int NCR_MAX = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_sd_cmd,
   output logic               o_sd_cmd,
   output logic               o_sd_cmd_dir,
   sd_dev_cmd_layer_if.slave  bus
);

   localparam int WW = $clog2(NCR_MAX + 1);
   localparam logic [WW-1:0] WAIT_SAT = WW'(NCR_MAX);

   typedef enum logic [1:0] {IDLE = 2'd0, RX = 2'd1, WAIT_RSP = 2'd2, TX = 2'd3} state_t;

   state_t         state_q, state_d;
   logic [7:0]     bit_cnt;
   logic [WW-1:0]  wait_cnt;
   logic [45:0]    rx_sr;      // rx_sr[j] holds token bit j+1 once bit 0 arrives
   logic [135:0]   tx_sr;
   logic [6:0]     crc;
   logic           rsp_vld, rsp_long;
   logic           cmd_stb_q, crc_err_q, frame_err_q;
   logic [5:0]     cmd_q;
   logic [31:0]    arg_q;

   function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
      logic fb;
      fb = c[6] ^ b;
      return {c[5:3], c[2] ^ fb, c[1:0], fb};
   endfunction

   // RX decode (valid in the cycle bit 0 is on the line)
   logic rx_last, rx_host, rx_crc_ok;
   assign rx_last   = (state_q == RX) && (bit_cnt == 8'd47);
   assign rx_host   = rx_sr[45];
   assign rx_crc_ok = (rx_sr[6:0] == crc);

   // WAIT_RSP control
   logic rsp_latch, tx_go, timeout;
   assign rsp_latch = (state_q == WAIT_RSP) && bus.i_rsp_en && !rsp_vld && !bus.i_rsp_skip;
   // tx_go is evaluated one cycle before the start bit appears, hence the +1
   assign tx_go     = rsp_vld && (int'(wait_cnt) + 1 >= NCR_MIN);
   assign timeout   = !rsp_vld && !bus.i_rsp_en && (int'(wait_cnt) >= NCR_MAX - 1);

   // TX frame layout: data bits, then 7 CRC bits, then end bit
   logic [7:0] tx_crc_lo, tx_crc_start, tx_end;
   logic       tx_bit, tx_last;
   assign tx_crc_lo    = rsp_long ? 8'd8   : 8'd0;   // R2 CRC skips the 00_111111 header
   assign tx_crc_start = rsp_long ? 8'd128 : 8'd40;
   assign tx_end       = rsp_long ? 8'd135 : 8'd47;
   assign tx_last      = (state_q == TX) && (bit_cnt == tx_end);
   assign tx_bit       = (bit_cnt < tx_crc_start) ? tx_sr[135] :
                         (bit_cnt < tx_end)       ? crc[6]     : 1'b1;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (!i_sd_cmd) state_d = RX;
         RX:       if (rx_last) state_d = (rx_host && i_sd_cmd && rx_crc_ok) ? WAIT_RSP : IDLE;
         WAIT_RSP: begin
            if (bus.i_rsp_skip)   state_d = IDLE;
            else if (tx_go)       state_d = TX;
            else if (timeout)     state_d = IDLE;
         end
         TX:       if (tx_last) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt     <= '0;
         wait_cnt    <= '0;
         rx_sr       <= '0;
         tx_sr       <= '0;
         crc         <= '0;
         rsp_vld     <= 1'b0;
         rsp_long    <= 1'b0;
         cmd_stb_q   <= 1'b0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         cmd_q       <= '0;
         arg_q       <= '0;
      end else begin
         cmd_stb_q   <= 1'b0;
         crc_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!i_sd_cmd) begin
                  // start bit (0) through a cleared CRC leaves it at 0
                  bit_cnt <= 8'd1;
                  crc     <= '0;
                  rx_sr   <= '0;
               end
            end
            RX: begin
               rx_sr   <= {rx_sr[44:0], i_sd_cmd};
               bit_cnt <= bit_cnt + 8'd1;
               if (bit_cnt < 8'd40) crc <= crc7_step(crc, i_sd_cmd);
               if (rx_last && rx_host) begin
                  // end bit checked before CRC so a doubly bad token reports framing only
                  if (!i_sd_cmd)       frame_err_q <= 1'b1;
                  else if (!rx_crc_ok) crc_err_q   <= 1'b1;
                  else begin
                     cmd_stb_q <= 1'b1;
                     cmd_q     <= rx_sr[44:39];
                     arg_q     <= rx_sr[38:7];
                     wait_cnt  <= '0;
                     rsp_vld   <= 1'b0;
                  end
               end
            end
            WAIT_RSP: begin
               if (wait_cnt != WAIT_SAT) wait_cnt <= wait_cnt + 1'b1;
               if (rsp_latch) begin
                  rsp_vld  <= 1'b1;
                  rsp_long <= bus.i_rsp_long_flag;
                  if (bus.i_rsp_long_flag) tx_sr <= {2'b00, 6'b111111, bus.i_rsp[127:8], 8'h00};
                  else                     tx_sr <= {2'b00, bus.i_rsp[37:0], 96'h0};
               end
               if (state_d == TX) begin
                  bit_cnt <= '0;
                  crc     <= '0;
               end
            end
            TX: begin
               bit_cnt <= bit_cnt + 8'd1;
               if (bit_cnt < tx_crc_start) begin
                  tx_sr <= {tx_sr[134:0], 1'b0};
                  if (bit_cnt >= tx_crc_lo) crc <= crc7_step(crc, tx_sr[135]);
               end else begin
                  crc <= {crc[5:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   assign o_sd_cmd        = (state_q == TX) ? tx_bit : 1'b1;
   assign o_sd_cmd_dir    = (state_q == TX);
   assign bus.o_cmd_stb   = cmd_stb_q;
   assign bus.o_crc_err   = crc_err_q;
   assign bus.o_frame_err = frame_err_q;
   assign bus.o_cmd       = cmd_q;
   assign bus.o_cmd_arg   = arg_q;
   assign bus.o_busy      = (state_q != IDLE);
   assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_sd_dev_cmd_layer.sv
// ---------------------------------------------------------------------------
// tb_sd_dev_cmd_layer
// Directed bench for the card-side SD command layer. Inputs change and
// outputs are sampled on the falling edge; the DUT works on the rising edge.
// ---------------------------------------------------------------------------
module tb_sd_dev_cmd_layer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_sd_cmd = 1'b1;
   logic o_sd_cmd, o_sd_cmd_dir;

   sd_dev_cmd_layer_if bus ();

   sd_dev_cmd_layer #(.NCR_MIN(2), .NCR_MAX(64)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_sd_cmd     (i_sd_cmd),
      .o_sd_cmd     (o_sd_cmd),
      .o_sd_cmd_dir (o_sd_cmd_dir),
      .bus          (bus.slave)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int pulse_cnt = 0;   // cycles with any of stb / crc_err / frame_err high
   int dir_cnt   = 0;   // cycles with the card driving CMD

   always @(negedge clk) begin
      if (bus.o_cmd_stb === 1'b1 || bus.o_crc_err === 1'b1 || bus.o_frame_err === 1'b1)
         pulse_cnt++;
      if (o_sd_cmd_dir === 1'b1) dir_cnt++;
   end

   localparam logic [127:0] CID = 128'h0123456789ABCDEF_FEDCBA9876543210;

   task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // CRC7 x^7+x^3+1 over d[n-1:0], MSB first
   function automatic logic [6:0] crc7(input logic [135:0] d, input int n);
      logic [6:0] c;
      logic fb;
      c = '0;
      for (int i = n - 1; i >= 0; i--) begin
         fb = c[6] ^ d[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   function automatic logic [47:0] mk_tok(input logic [1:0] hdr, input logic [5:0] idx,
                                          input logic [31:0] arg);
      logic [39:0] body;
      body = {hdr, idx, arg};
      return {body, crc7({96'h0, body}, 40), 1'b1};
   endfunction

   // Caller is at a falling edge; returns at the falling edge of the cycle
   // after the end bit was sampled (the strobe cycle).
   task automatic send_token(input logic [47:0] tok);
      for (int i = 47; i >= 0; i--) begin
         i_sd_cmd = tok[i];
         @(negedge clk);
      end
      i_sd_cmd = 1'b1;
   endtask

   // Called in the strobe cycle with i_rsp_en already raised. Checks the
   // start-bit latency, captures n frame bits and the release afterwards.
   task automatic rsp_seq(input string pfx, input int n, input logic [135:0] exp, input bit second);
      logic [135:0] got;
      int bad;
      @(negedge clk);
      if (second) begin
         bus.i_rsp       = '1;      // extra request while one is latched: must be ignored
         bus.i_rsp_long_flag = 1'b0;
      end else begin
         bus.i_rsp_en = 1'b0;
      end
      check({pfx, "_lat1_dir"}, o_sd_cmd_dir, 1'b0);
      @(negedge clk);
      bus.i_rsp_en = 1'b0;
      check({pfx, "_lat2_dir"}, o_sd_cmd_dir, 1'b1);
      got = '0;
      bad = 0;
      for (int i = 0; i < n; i++) begin
         got = {got[134:0], o_sd_cmd};
         if (o_sd_cmd_dir !== 1'b1) bad++;
         @(negedge clk);
      end
      check({pfx, "_frame"}, got, exp);
      check({pfx, "_dir_hold"}, bad, 0);
      check({pfx, "_post_dir"}, o_sd_cmd_dir, 1'b0);
      check({pfx, "_post_line"}, o_sd_cmd, 1'b1);
      check({pfx, "_post_busy"}, bus.o_busy, 1'b0);
   endtask

   initial begin
      logic [39:0]  sh;
      logic [119:0] pl;
      logic [135:0] exp;
      int p0, d0, cnt;

      bus.i_rsp_en = 1'b0;
      bus.i_rsp_skip = 1'b0;
      bus.i_rsp_long_flag = 1'b0;
      bus.i_rsp = '0;

      // ---- reset state
      repeat (3) @(negedge clk);
      check("rst_line", o_sd_cmd, 1'b1);
      check("rst_dir", o_sd_cmd_dir, 1'b0);
      check("rst_stb", bus.o_cmd_stb, 1'b0);
      check("rst_crc_err", bus.o_crc_err, 1'b0);
      check("rst_frame_err", bus.o_frame_err, 1'b0);
      check("rst_busy", bus.o_busy, 1'b0);
      check("rst_cmd", bus.o_cmd, 6'd0);
      check("rst_arg", bus.o_cmd_arg, 32'd0);
      rst = 1'b0;

      // ---- response request while idle is ignored
      @(negedge clk);
      bus.i_rsp_en = 1'b1;
      @(negedge clk);
      bus.i_rsp_en = 1'b0;
      @(negedge clk);
      check("idle_rsp_en_busy", bus.o_busy, 1'b0);
      check("idle_rsp_en_dir", o_sd_cmd_dir, 1'b0);

      // ---- CMD0, skip together with rsp_en: skip wins
      d0 = dir_cnt;
      send_token(48'h40_0000_0000_95);
      check("cmd0_stb", bus.o_cmd_stb, 1'b1);
      check("cmd0_idx", bus.o_cmd, 6'd0);
      check("cmd0_arg", bus.o_cmd_arg, 32'h0);
      check("cmd0_crc_err", bus.o_crc_err, 1'b0);
      check("cmd0_busy", bus.o_busy, 1'b1);
      bus.i_rsp_skip = 1'b1;
      bus.i_rsp_en = 1'b1;
      bus.i_rsp = 128'hFF;
      @(negedge clk);
      bus.i_rsp_skip = 1'b0;
      bus.i_rsp_en = 1'b0;
      check("cmd0_stb_pulse", bus.o_cmd_stb, 1'b0);
      check("cmd0_skip_idle", bus.o_busy, 1'b0);
      repeat (4) @(negedge clk);
      check("cmd0_no_drive", dir_cnt - d0, 0);

      // ---- CMD8, short R7 response
      send_token(48'h48_0000_01AA_87);
      check("cmd8_stb", bus.o_cmd_stb, 1'b1);
      check("cmd8_idx", bus.o_cmd, 6'd8);
      check("cmd8_arg", bus.o_cmd_arg, 32'h1AA);
      bus.i_rsp_en = 1'b1;
      bus.i_rsp_long_flag = 1'b0;
      bus.i_rsp = {90'h0, 6'd8, 32'h1AA};
      sh = {2'b00, 6'd8, 32'h1AA};
      exp = {88'h0, sh, crc7({96'h0, sh}, 40), 1'b1};
      rsp_seq("r7", 48, exp, 1'b0);

      // ---- CRC error, then framing error, then valid CMD0, each back-to-back
      send_token(48'h48_0000_01AA_85);
      check("crc_err_pulse", bus.o_crc_err, 1'b1);
      check("crc_err_no_stb", bus.o_cmd_stb, 1'b0);
      check("crc_err_no_frame", bus.o_frame_err, 1'b0);
      check("crc_err_idle", bus.o_busy, 1'b0);
      check("crc_err_cmd_hold", bus.o_cmd, 6'd8);
      send_token(48'h48_0000_01AA_84);
      check("frame_err_pulse", bus.o_frame_err, 1'b1);
      check("frame_err_no_crc", bus.o_crc_err, 1'b0);
      check("frame_err_no_stb", bus.o_cmd_stb, 1'b0);
      send_token(48'h40_0000_0000_95);
      check("b2b_stb", bus.o_cmd_stb, 1'b1);
      check("b2b_idx", bus.o_cmd, 6'd0);
      bus.i_rsp_skip = 1'b1;
      @(negedge clk);
      bus.i_rsp_skip = 1'b0;
      check("b2b_skip_idle", bus.o_busy, 1'b0);

      // ---- CMD2, long R2 response; second rsp_en ignored
      send_token(mk_tok(2'b01, 6'd2, 32'h0));
      check("cmd2_stb", bus.o_cmd_stb, 1'b1);
      check("cmd2_idx", bus.o_cmd, 6'd2);
      bus.i_rsp_en = 1'b1;
      bus.i_rsp_long_flag = 1'b1;
      bus.i_rsp = CID;
      pl = CID[127:8];
      exp = {2'b00, 6'b111111, pl, crc7({16'h0, pl}, 120), 1'b1};
      rsp_seq("r2", 136, exp, 1'b1);

      // ---- no response: busy drops after exactly NCR_MAX cycles
      d0 = dir_cnt;
      send_token(48'h40_0000_0000_95);
      check("to_stb", bus.o_cmd_stb, 1'b1);
      cnt = 0;
      while (bus.o_busy === 1'b1 && cnt < 200) begin
         cnt++;
         @(negedge clk);
      end
      check("to_busy_cycles", cnt, 64);
      check("to_no_drive", dir_cnt - d0, 0);

      // ---- transmission bit 0: discarded without any pulse
      p0 = pulse_cnt;
      send_token(mk_tok(2'b00, 6'd8, 32'h1AA));
      repeat (3) @(negedge clk);
      check("txbit0_no_pulse", pulse_cnt - p0, 0);
      check("txbit0_idle", bus.o_busy, 1'b0);

      // ---- reset at bit 20 of a long response
      send_token(mk_tok(2'b01, 6'd2, 32'h0));
      bus.i_rsp_en = 1'b1;
      bus.i_rsp_long_flag = 1'b1;
      bus.i_rsp = CID;
      @(negedge clk);
      bus.i_rsp_en = 1'b0;
      @(negedge clk);
      repeat (20) @(negedge clk);
      check("abort_pre_dir", o_sd_cmd_dir, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_dir", o_sd_cmd_dir, 1'b0);
      check("abort_line", o_sd_cmd, 1'b1);
      check("abort_busy", bus.o_busy, 1'b0);
      check("abort_cmd_clr", bus.o_cmd, 6'd0);
      rst = 1'b0;
      @(negedge clk);
      send_token(48'h40_0000_0000_95);
      check("post_rst_stb", bus.o_cmd_stb, 1'b1);
      check("post_rst_idx", bus.o_cmd, 6'd0);
      check("post_rst_arg", bus.o_cmd_arg, 32'h0);
      bus.i_rsp_skip = 1'b1;
      @(negedge clk);
      bus.i_rsp_skip = 1'b0;
      check("post_rst_idle", bus.o_busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sd_dev_cmd_layer.md
# sd_dev_cmd_layer

Card-side (device-end) command/response engine for the SD/SDIO CMD line: the counterpart of the host command layer and PHY. It deserialises 48-bit host command tokens, checks framing and CRC7, presents index and argument to the card logic, then serialises the R1/R3/R6/R7 (48-bit) or R2 (136-bit) response with generated CRC7. It runs entirely in the SD clock domain and is the core of the card model used in host-stack simulation and of a future FPGA SD-device target.

## Interface
Parameters:
- NCR_MIN, 2: minimum cycles from command end bit to response start bit
- NCR_MAX, 64: cycles in WAIT_RSP without i_rsp_en or i_rsp_skip before silently returning to IDLE

Ports:
- clk  input  1  SD clock; all I/O sampled and driven on rising edge
- rst  input  1  synchronous, active-high reset
- i_sd_cmd  input  1  CMD line as seen by the card
- o_sd_cmd  output  1  CMD value driven by the card
- o_sd_cmd_dir  output  1  1 = card drives CMD, 0 = released
- o_cmd_stb  output  1  one-cycle pulse: valid command in o_cmd/o_cmd_arg
- o_cmd  output  6  received command index
- o_cmd_arg  output  32  received argument
- o_crc_err  output  1  one-cycle pulse: command CRC7 mismatch
- o_frame_err  output  1  one-cycle pulse: end bit was 0
- i_rsp_en  input  1  pulse: load response, accepted only in WAIT_RSP
- i_rsp_skip  input  1  pulse: no response for this command, return to IDLE
- i_rsp_long_flag  input  1  sampled with i_rsp_en: 1 = 136-bit R2
- i_rsp  input  128  short: [37:0] = index+argument; long: [127:8] = CID/CSD payload
- o_busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, RX, WAIT_RSP, TX.
- IDLE: o_sd_cmd_dir=0. A sampled 0 on i_sd_cmd is the start bit -> RX, bit counter=1, CRC7 register cleared, then start bit shifted into CRC.
- RX: shift 47 more bits into a 48-bit register; CRC7 (x^7+x^3+1, init 0) runs over bits 47..8. After bit 0 (end bit):
  - transmission bit (bit 46) = 0: token is not from host; discard silently -> IDLE.
  - end bit 0: pulse o_frame_err -> IDLE (checked before CRC; a token with both faults reports only o_frame_err).
  - received CRC (bits 7..1) != computed: pulse o_crc_err -> IDLE.
  - otherwise: o_cmd=bits 45..40, o_cmd_arg=bits 39..8, pulse o_cmd_stb -> WAIT_RSP. o_cmd/o_cmd_arg hold until next valid command.
- WAIT_RSP: wait counter starts at 0 on the cycle after the end bit. i_rsp_skip -> IDLE (skip has priority over simultaneous i_rsp_en). i_rsp_en latches i_rsp and i_rsp_long_flag into the shift register. Transmission starts on the first cycle where a response is latched and wait counter >= NCR_MIN. Counter reaching NCR_MAX with no response latched -> IDLE with no output. i_sd_cmd ignored in this state.
- TX frame, MSB first: short = 0, 0, i_rsp[37:0], CRC7 over preceding 40 bits, 1 (48 bits); long = 0, 0, 6'b111111, i_rsp[127:8], CRC7 over i_rsp[127:8] only, 1 (136 bits). o_sd_cmd_dir=1 for every frame bit; cycle after end bit dir=0, o_sd_cmd=1 -> IDLE.
- i_rsp_en outside WAIT_RSP, and a second i_rsp_en after one is latched, are ignored.

## Timing
- Reset: state IDLE, o_sd_cmd=1, o_sd_cmd_dir=0, o_cmd_stb=0, o_crc_err=0, o_frame_err=0, o_busy=0, o_cmd=0, o_cmd_arg=0. Reset mid-RX or mid-TX aborts immediately; line released the next cycle.
- o_cmd_stb / o_crc_err / o_frame_err assert in the cycle after the end bit is sampled.
- With i_rsp_en asserted in the o_cmd_stb cycle and NCR_MIN=2, the response start bit is driven 2 cycles after the end-bit sample cycle. Response latency from start bit is 48 or 136 cycles to end bit inclusive.
- Back-to-back: a start bit sampled in the cycle immediately after returning to IDLE is accepted; minimum command-to-command gap is therefore one idle cycle.
- Counters: bit counter 8 bits, wait counter 7 bits (saturating); widths scale with NCR_MAX.

## Test plan
- CMD0, arg 0x00000000, CRC 0x4A (bytes 40 00 00 00 00 95) -> o_cmd_stb, o_cmd=0, arg=0; i_rsp_skip -> IDLE, o_sd_cmd_dir never high.
- CMD8, arg 0x000001AA (bytes 48 00 00 01 AA 87) -> o_cmd=8, arg=0x1AA; i_rsp_en with i_rsp[37:0]={6'd8, 32'h1AA} -> 48-bit frame starting 2 cycles after end bit, CRC matches a software CRC7 model, dir drops after end bit.
- CMD8 with last CRC byte 0x85 -> o_crc_err pulse, no o_cmd_stb, state IDLE; same token with end bit 0 -> o_frame_err only.
- CMD2, then i_rsp_en with i_rsp_long_flag=1 and CID=0x0123456789ABCDEF_FEDCBA9876543210 -> 136 bits: 00, 111111, payload[127:8], model CRC7, 1.
- Valid command, no i_rsp_en -> o_busy falls exactly after NCR_MAX cycles, no line activity; token with transmission bit 0 -> no pulses at all.
- Reset asserted at bit 20 of a long response -> next cycle o_sd_cmd_dir=0, o_sd_cmd=1; subsequent CMD0 decoded correctly.
